// File: rtl/stream_scheduler_rr_if.sv
// Stream scheduler handshake bundle: FIFO status and host controls in,
// mux select and status strobes out.
interface stream_scheduler_rr_if #(
  parameter int unsigned NUM_STREAMS = 8,
  parameter int unsigned SEL_W       = 3
);
  logic                   sending_flag;
  logic                   packet_sent;
  logic [NUM_STREAMS-1:0] empty_fifo_flags;
  logic [NUM_STREAMS-1:0] selected_streams;
  logic [SEL_W-1:0]       mux_select;
  logic                   select_ready;
  logic                   grant_pulse;
  logic                   no_data;

  // Host / FIFO-bank side: drives controls, observes the grant.
  modport master (
    output sending_flag, packet_sent, empty_fifo_flags, selected_streams,
    input  mux_select, select_ready, grant_pulse, no_data
  );

  // Scheduler side.
  modport slave (
    input  sending_flag, packet_sent, empty_fifo_flags, selected_streams,
    output mux_select, select_ready, grant_pulse, no_data
  );
endinterface

// File: rtl/stream_scheduler_rr.sv
// Round-robin scheduler choosing which datastream FIFO feeds the shared
// transmit path. Grants are bounded by a cycle timer and a packet burst
// limit; a packet in flight is never cut off.
module stream_scheduler_rr #(
  parameter int unsigned NUM_STREAMS = 8,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned TIMER_W     = 32,
  parameter int unsigned TIMER_CAP   = 35000,
  parameter int unsigned MAX_PACKETS = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  stream_scheduler_rr_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NUM_STREAMS + 1);
  localparam int unsigned PKT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIND,
    S_RUN,
    S_CHECK
  } state_t;

  state_t                 state, state_nx;
  logic [NUM_STREAMS-1:0] mask;
  logic [SEL_W-1:0]       ptr;
  logic [CNT_W-1:0]       scan_cnt;
  logic [TIMER_W-1:0]     timer;
  logic [PKT_W-1:0]       pkt_cnt;
  logic                   fresh;

  logic                   hit;
  logic                   timer_done;
  logic                   burst_done;
  logic                   leave;
  logic [SEL_W-1:0]       ptr_adv;

  assign hit        = mask[ptr] & ~bus.empty_fifo_flags[ptr];
  assign timer_done = (timer == TIMER_W'(TIMER_CAP));
  assign burst_done = (MAX_PACKETS != 0) && (pkt_cnt == PKT_W'(MAX_PACKETS));
  assign leave      = bus.empty_fifo_flags[ptr] | timer_done | burst_done;
  // Explicit wrap keeps ptr in range when NUM_STREAMS is not a power of two.
  assign ptr_adv    = (ptr == SEL_W'(NUM_STREAMS - 1)) ? '0 : ptr + 1'b1;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state decision.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.sending_flag) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_FIND;
      S_FIND: begin
        if (!bus.sending_flag) state_nx = S_IDLE;
        else if (hit)          state_nx = S_RUN;
      end
      S_RUN:   if (bus.packet_sent) state_nx = S_CHECK;
      S_CHECK: begin
        if (!bus.sending_flag) state_nx = S_IDLE;
        else if (leave)        state_nx = S_FIND;
        else                   state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pointer, scan counter, grant timer and packet counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mask     <= '0;
      ptr      <= '0;
      scan_cnt <= '0;
      timer    <= '0;
      pkt_cnt  <= '0;
      fresh    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mask     <= '0;
          ptr      <= '0;
          scan_cnt <= '0;
          timer    <= '0;
          pkt_cnt  <= '0;
          fresh    <= 1'b0;
        end
        S_LOAD: begin
          mask     <= bus.selected_streams;
          ptr      <= '0;
          scan_cnt <= '0;
        end
        S_FIND: begin
          if (bus.sending_flag) begin
            if (hit) begin
              timer    <= '0;
              pkt_cnt  <= '0;
              scan_cnt <= '0;
              fresh    <= 1'b1;
            end else begin
              ptr <= ptr_adv;
              if (scan_cnt != CNT_W'(NUM_STREAMS)) scan_cnt <= scan_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          fresh <= 1'b0;
          if (!timer_done) timer <= timer + 1'b1;
          if (bus.packet_sent && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + 1'b1;
        end
        S_CHECK: begin
          if (bus.sending_flag && leave) ptr <= ptr_adv;
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure functions of registered state.
  assign bus.select_ready = (state == S_RUN);
  assign bus.mux_select   = (state == S_RUN) ? ptr : '0;
  assign bus.grant_pulse  = (state == S_RUN) & fresh;
  assign bus.no_data      = (state == S_FIND) && (scan_cnt == CNT_W'(NUM_STREAMS));

endmodule

// File: tb/tb_stream_scheduler_rr.sv
// Randomised bench for stream_scheduler_rr against a cycle-level model of
// the scheduling rules, using a non-power-of-two stream count.
module tb_stream_scheduler_rr;

  localparam int unsigned NS   = 6;
  localparam int unsigned SW   = 3;
  localparam int unsigned TW   = 8;
  localparam int unsigned CAP  = 12;
  localparam int unsigned MAXP = 3;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  stream_scheduler_rr_if #(.NUM_STREAMS(NS), .SEL_W(SW)) bus ();

  stream_scheduler_rr #(
    .NUM_STREAMS(NS),
    .SEL_W(SW),
    .TIMER_W(TW),
    .TIMER_CAP(CAP),
    .MAX_PACKETS(MAXP)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase names as plain ints, ptr advance by modulo.
  localparam int P_IDLE = 0, P_LOAD = 1, P_FIND = 2, P_RUN = 3, P_CHECK = 4;
  int          m_phase, m_ptr, m_scanned, m_timer, m_pkts;
  logic [NS-1:0] m_mask;
  bit          m_new_grant;

  task automatic model_reset();
    m_phase = P_IDLE; m_ptr = 0; m_scanned = 0; m_timer = 0; m_pkts = 0;
    m_mask = '0; m_new_grant = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    case (m_phase)
      P_IDLE: begin
        model_reset();
        if (bus.sending_flag) m_phase = P_LOAD;
      end
      P_LOAD: begin
        m_mask = bus.selected_streams; m_ptr = 0; m_scanned = 0; m_phase = P_FIND;
      end
      P_FIND: begin
        if (!bus.sending_flag) m_phase = P_IDLE;
        else if (m_mask[m_ptr] && !bus.empty_fifo_flags[m_ptr]) begin
          m_phase = P_RUN; m_timer = 0; m_pkts = 0; m_scanned = 0; m_new_grant = 1;
        end else begin
          m_ptr = (m_ptr + 1) % NS;
          if (m_scanned < NS) m_scanned++;
        end
      end
      P_RUN: begin
        m_new_grant = 0;
        if (m_timer < CAP) m_timer++;
        if (bus.packet_sent) begin
          if (m_pkts < 255) m_pkts++;
          m_phase = P_CHECK;
        end
      end
      default: begin
        if (!bus.sending_flag) m_phase = P_IDLE;
        else if (bus.empty_fifo_flags[m_ptr] || m_timer == CAP || (MAXP != 0 && m_pkts == MAXP)) begin
          m_ptr = (m_ptr + 1) % NS; m_phase = P_FIND;
        end else m_phase = P_RUN;
      end
    endcase
  endtask

  task automatic compare_all(input string where);
    bit run;
    run = (m_phase == P_RUN);
    check_val({where, ".select_ready"}, 32'(bus.select_ready), 32'(run));
    check_val({where, ".mux_select"},   32'(bus.mux_select),   run ? 32'(m_ptr) : 32'd0);
    check_val({where, ".grant_pulse"},  32'(bus.grant_pulse),  32'(run && m_new_grant));
    check_val({where, ".no_data"},      32'(bus.no_data),      32'(m_phase == P_FIND && m_scanned == NS));
  endtask

  task automatic step(input string where);
    model_next();
    @(posedge clock);
    #1;
    compare_all(where);
  endtask

  task automatic async_reset_pulse();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clock);
    #1 compare_all("rst_hold");
    @(negedge clock) resetn = 1'b1;
  endtask

  int  want_reset;
  int  grants;
  logic [NS-1:0] tmp;

  initial begin
    resetn = 1'b0;
    bus.sending_flag = 1'b0;
    bus.packet_sent = 1'b0;
    bus.empty_fifo_flags = '0;
    bus.selected_streams = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 compare_all("reset");
    @(negedge clock) resetn = 1'b1;

    // Everything enabled but empty: scan must saturate and flag no_data.
    bus.sending_flag = 1'b1;
    bus.selected_streams = '1;
    bus.empty_fifo_flags = '1;
    repeat (20) step("nodata");
    check_val("nodata_seen", 32'(bus.no_data), 32'd1);
    tmp = '1;
    tmp[5] = 1'b0;
    bus.empty_fifo_flags = tmp;
    repeat (8) step("nodata_clear");
    check_val("grant_stream5", 32'(bus.mux_select), 32'd5);

    // Randomised traffic with occasional mid-RUN asynchronous reset.
    want_reset = 0;
    grants = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) bus.sending_flag = ~bus.sending_flag;
      bus.packet_sent = ($urandom_range(0, 4) == 0);
      bus.selected_streams = NS'($urandom);
      if (i % 6 == 0) begin
        for (int k = 0; k < NS; k++) tmp[k] = ($urandom_range(0, 99) < 30);
        bus.empty_fifo_flags = tmp;
      end
      step("rand");
      if (bus.grant_pulse) grants++;
      if (i % 800 == 400) want_reset = 1;
      if (want_reset != 0 && m_phase == P_RUN) begin
        want_reset = 0;
        async_reset_pulse();
      end
    end
    check_val("grants_happened", 32'(grants > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
